// File: rtl/cc_ctrl_fsm_pkg.sv
// Shared types and geometry for the cache lookup controller: 256 x 64 B
// direct-mapped read-only cache, line filled in 8 beats of 64 b.
package cc_pkg;

    localparam int ADDR_W     = 32;
    localparam int IDX_W      = 8;
    localparam int OFS_W      = 6;
    localparam int TAG_W      = ADDR_W - IDX_W - OFS_W;
    localparam int BEAT_W     = 3;
    localparam int LINE_BEATS = 8;
    localparam int PERF_W     = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [TAG_W-1:0]  tag_t;
    typedef logic [IDX_W-1:0]  idx_t;
    typedef logic [OFS_W-1:0]  ofs_t;
    typedef logic [BEAT_W-1:0] beat_t;

    typedef struct packed {
        tag_t tag;
        idx_t idx;
        ofs_t ofs;
    } cc_addr_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOOKUP,
        ST_MREQ,
        ST_FILL,
        ST_SERVE
    } cc_state_t;

    function automatic addr_t line_addr(input tag_t tag, input idx_t idx);
        return {tag, idx, {OFS_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cc_ctrl_fsm_if.sv
// Bundle of requester, comparator, memory, SRAM-write and serializer signals
// around the cache controller; master = controller side, slave = environment.
interface cc_ctrl_fsm_if;
    import cc_pkg::*;

    logic                inct_arvalid_i;
    logic                inct_arready_o;
    addr_t               inct_araddr_i;
    logic                hs_pulse_o;
    logic                hit_i;
    logic                miss_i;
    logic                mem_arvalid_o;
    logic                mem_arready_i;
    addr_t               mem_araddr_o;
    logic                mem_rvalid_i;
    logic                mem_rlast_i;
    logic                mem_rready_o;
    logic                wren_tag_o;
    logic [TAG_W:0]      wdata_tag_o;
    idx_t                waddr_o;
    logic                wren_data_o;
    beat_t               wbeat_o;
    logic                serve_o;
    ofs_t                serve_offset_o;
    logic                serve_done_i;

    modport master (
        input  inct_arvalid_i, inct_araddr_i, hit_i, miss_i, mem_arready_i,
               mem_rvalid_i, mem_rlast_i, serve_done_i,
        output inct_arready_o, hs_pulse_o, mem_arvalid_o, mem_araddr_o,
               mem_rready_o, wren_tag_o, wdata_tag_o, waddr_o, wren_data_o,
               wbeat_o, serve_o, serve_offset_o
    );

    modport slave (
        output inct_arvalid_i, inct_araddr_i, hit_i, miss_i, mem_arready_i,
               mem_rvalid_i, mem_rlast_i, serve_done_i,
        input  inct_arready_o, hs_pulse_o, mem_arvalid_o, mem_araddr_o,
               mem_rready_o, wren_tag_o, wdata_tag_o, waddr_o, wren_data_o,
               wbeat_o, serve_o, serve_offset_o
    );

endinterface

// File: rtl/cc_ctrl_fsm.sv
// Cache lookup sequencer: tag invalidation sweep, lookup, line fill, serve.
// Define CC_PERF_CNT_EN to add saturating hit/miss counters.
module cc_ctrl_fsm
    import cc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    cc_ctrl_fsm_if.master     bus
`ifdef CC_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] hit_cnt_o,
    output logic [PERF_W-1:0] miss_cnt_o
`endif
);

    cc_state_t r_state;
    idx_t      r_cnt;
    logic      r_init_go;
    cc_addr_t  r_req;
    logic      r_arready;
    logic      r_mem_arvalid;
    logic      r_rready;
    logic      r_serve;

    logic      w_hs;
    logic      w_fill;
    logic      w_beat;
    logic      w_last;
    logic      w_init_wr;
    logic      w_miss;

    assign w_hs      = bus.inct_arvalid_i & r_arready;
    assign w_fill    = (r_state == ST_FILL);
    assign w_beat    = w_fill & bus.mem_rvalid_i;
    assign w_last    = w_beat & bus.mem_rlast_i;
    // r_init_go keeps the tag write quiet while reset is held in INIT
    assign w_init_wr = (r_state == ST_INIT) & r_init_go;
    // a lookup with no comparator answer is handled as a miss
    assign w_miss    = bus.miss_i | ~bus.hit_i;

    assign bus.inct_arready_o = r_arready;
    assign bus.hs_pulse_o     = w_hs;
    assign bus.mem_arvalid_o  = r_mem_arvalid;
    assign bus.mem_araddr_o   = line_addr(r_req.tag, r_req.idx);
    assign bus.mem_rready_o   = r_rready;
    assign bus.wren_tag_o     = w_init_wr | w_last;
    assign bus.wdata_tag_o    = w_last ? {1'b1, r_req.tag} : '0;
    assign bus.waddr_o        = w_init_wr ? r_cnt : (w_fill ? r_req.idx : '0);
    assign bus.wren_data_o    = w_beat;
    assign bus.wbeat_o        = w_fill ? r_cnt[BEAT_W-1:0] : '0;
    assign bus.serve_o        = r_serve;
    assign bus.serve_offset_o = r_req.ofs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_INIT;
            r_cnt         <= '0;
            r_init_go     <= 1'b0;
            r_req         <= '0;
            r_arready     <= 1'b0;
            r_mem_arvalid <= 1'b0;
            r_rready      <= 1'b0;
            r_serve       <= 1'b0;
        end else begin
            r_serve <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    if (!r_init_go) begin
                        r_init_go <= 1'b1;
                    end else if (r_cnt == '1) begin
                        r_init_go <= 1'b0;
                        r_cnt     <= '0;
                        r_arready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + idx_t'(1);
                    end
                end
                ST_IDLE: begin
                    if (w_hs) begin
                        r_req     <= cc_addr_t'(bus.inct_araddr_i);
                        r_arready <= 1'b0;
                        r_state   <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (bus.hit_i) begin
                        r_serve <= 1'b1;
                        r_state <= ST_SERVE;
                    end else if (w_miss) begin
                        r_mem_arvalid <= 1'b1;
                        r_state       <= ST_MREQ;
                    end
                end
                ST_MREQ: begin
                    if (bus.mem_arready_i) begin
                        r_mem_arvalid <= 1'b0;
                        r_rready      <= 1'b1;
                        r_cnt         <= '0;
                        r_state       <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (w_beat) begin
                        // beat index wraps within the line if rlast never comes
                        r_cnt <= idx_t'(beat_t'(r_cnt[BEAT_W-1:0] + beat_t'(1)));
                        if (bus.mem_rlast_i) begin
                            r_rready <= 1'b0;
                            r_serve  <= 1'b1;
                            r_state  <= ST_SERVE;
                        end
                    end
                end
                ST_SERVE: begin
                    if (bus.serve_done_i) begin
                        r_arready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

`ifdef CC_PERF_CNT_EN
    logic [PERF_W-1:0] r_hit_cnt;
    logic [PERF_W-1:0] r_miss_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == ST_LOOKUP) begin
            if (bus.hit_i) begin
                if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + PERF_W'(1);
            end else if (w_miss) begin
                if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + PERF_W'(1);
            end
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_cc_ctrl_fsm.sv
// Directed bench for cc_ctrl_fsm: init sweep, hit, miss fill, back-to-back,
// reset during fill; counter checks when CC_PERF_CNT_EN is defined.
module tb_cc_ctrl_fsm;
    import cc_pkg::*;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   bad;

    cc_ctrl_fsm_if bus ();

`ifdef CC_PERF_CNT_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    cc_ctrl_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef CC_PERF_CNT_EN
        ,
        .hit_cnt_o  (hit_cnt),
        .miss_cnt_o (miss_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // inputs change and outputs are sampled 2-3 time units after a rising edge
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_hit(input logic [31:0] addr, input logic [5:0] ofs);
        bus.inct_arvalid_i = 1'b1;
        bus.inct_araddr_i  = addr;
        #1;
        chk("hit_hs_pulse", 64'(bus.hs_pulse_o), 64'(1));
        cyc();
        bus.inct_arvalid_i = 1'b0;
        bus.hit_i          = 1'b1;
        #1;
        chk("hit_lookup_arready", 64'(bus.inct_arready_o), 64'(0));
        chk("hit_lookup_serve", 64'(bus.serve_o), 64'(0));
        cyc();
        bus.hit_i        = 1'b0;
        bus.serve_done_i = 1'b1;
        #1;
        chk("hit_serve_pulse", 64'(bus.serve_o), 64'(1));
        chk("hit_serve_offset", 64'(bus.serve_offset_o), 64'(ofs));
        chk("hit_no_mem_arvalid", 64'(bus.mem_arvalid_o), 64'(0));
        cyc();
        bus.serve_done_i = 1'b0;
        #1;
        chk("hit_back_idle_serve", 64'(bus.serve_o), 64'(0));
        chk("hit_back_idle_arready", 64'(bus.inct_arready_o), 64'(1));
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        bus.inct_arvalid_i = 1'b0;
        bus.inct_araddr_i  = '0;
        bus.hit_i          = 1'b0;
        bus.miss_i         = 1'b0;
        bus.mem_arready_i  = 1'b0;
        bus.mem_rvalid_i   = 1'b0;
        bus.mem_rlast_i    = 1'b0;
        bus.serve_done_i   = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk("rst_wren_tag", 64'(bus.wren_tag_o), 64'(0));
        chk("rst_waddr", 64'(bus.waddr_o), 64'(0));
        chk("rst_arready", 64'(bus.inct_arready_o), 64'(0));
        chk("rst_mem_arvalid", 64'(bus.mem_arvalid_o), 64'(0));
        chk("rst_serve", 64'(bus.serve_o), 64'(0));
        rst_n = 1'b1;

        // invalidation sweep: 256 consecutive tag writes of zero
        cyc();
        #1;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            if (!(bus.wren_tag_o === 1'b1 && bus.waddr_o === 8'(i) &&
                  bus.wdata_tag_o === 19'h0 && bus.inct_arready_o === 1'b0))
                bad++;
            cyc();
            #1;
        end
        chk("init_sweep_bad_cycles", 64'(bad), 64'(0));
        chk("init_done_wren_tag", 64'(bus.wren_tag_o), 64'(0));
        chk("init_done_arready", 64'(bus.inct_arready_o), 64'(1));

        do_hit(32'h1234_5678, 6'h38);

        // miss with a stalled memory request and bubbled beats
        bus.inct_arvalid_i = 1'b1;
        bus.inct_araddr_i  = 32'h0000_1040;
        #1;
        chk("miss_hs_pulse", 64'(bus.hs_pulse_o), 64'(1));
        cyc();
        bus.inct_arvalid_i = 1'b0;
        bus.miss_i         = 1'b1;
        #1;
        chk("miss_lookup_mem_arvalid", 64'(bus.mem_arvalid_o), 64'(0));
        cyc();
        bus.miss_i = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("miss_mreq_stall_valid", 64'(bus.mem_arvalid_o), 64'(1));
            chk("miss_mreq_stall_addr", 64'(bus.mem_araddr_o), 64'h1040);
            cyc();
            #1;
        end
        bus.mem_arready_i = 1'b1;
        #1;
        chk("miss_mreq_hs_valid", 64'(bus.mem_arvalid_o), 64'(1));
        chk("miss_mreq_hs_addr", 64'(bus.mem_araddr_o), 64'h1040);
        cyc();
        bus.mem_arready_i = 1'b0;
        #1;
        chk("miss_fill_arvalid_low", 64'(bus.mem_arvalid_o), 64'(0));
        chk("miss_fill_rready", 64'(bus.mem_rready_o), 64'(1));
        for (int b = 0; b < 8; b++) begin
            if (b % 2 == 1) begin
                bus.mem_rvalid_i = 1'b0;
                #1;
                chk("miss_bubble_wren_data", 64'(bus.wren_data_o), 64'(0));
                cyc();
            end
            bus.mem_rvalid_i = 1'b1;
            bus.mem_rlast_i  = (b == 7);
            #1;
            chk("miss_beat_wren_data", 64'(bus.wren_data_o), 64'(1));
            chk("miss_beat_wbeat", 64'(bus.wbeat_o), 64'(b));
            chk("miss_beat_waddr", 64'(bus.waddr_o), 64'h41);
            chk("miss_beat_wren_tag", 64'(bus.wren_tag_o), 64'(b == 7));
            if (b == 7) chk("miss_tag_wdata", 64'(bus.wdata_tag_o), 64'h40000);
            cyc();
        end
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rlast_i  = 1'b0;
        #1;
        chk("miss_serve_pulse", 64'(bus.serve_o), 64'(1));
        chk("miss_serve_offset", 64'(bus.serve_offset_o), 64'h0);
        chk("miss_serve_rready", 64'(bus.mem_rready_o), 64'(0));
        chk("miss_serve_wren_tag", 64'(bus.wren_tag_o), 64'(0));

        // second request waits in SERVE until serve_done_i
        bus.inct_arvalid_i = 1'b1;
        bus.inct_araddr_i  = 32'h1234_5678;
        #1;
        chk("b2b_serve_arready", 64'(bus.inct_arready_o), 64'(0));
        chk("b2b_serve_hs", 64'(bus.hs_pulse_o), 64'(0));
        cyc();
        #1;
        chk("b2b_serve_single_pulse", 64'(bus.serve_o), 64'(0));
        chk("b2b_serve_arready2", 64'(bus.inct_arready_o), 64'(0));
        cyc();
        bus.serve_done_i = 1'b1;
        #1;
        chk("b2b_done_arready", 64'(bus.inct_arready_o), 64'(0));
        cyc();
        bus.serve_done_i = 1'b0;
        #1;
        chk("b2b_idle_arready", 64'(bus.inct_arready_o), 64'(1));
        chk("b2b_idle_hs", 64'(bus.hs_pulse_o), 64'(1));
        cyc();
        bus.inct_arvalid_i = 1'b0;
        bus.hit_i          = 1'b1;
        cyc();
        bus.hit_i        = 1'b0;
        bus.serve_done_i = 1'b1;
        #1;
        chk("b2b_serve_pulse", 64'(bus.serve_o), 64'(1));
        chk("b2b_serve_offset", 64'(bus.serve_offset_o), 64'h38);
        cyc();
        bus.serve_done_i = 1'b0;

        do_hit(32'hABCD_EF07, 6'h07);

        // second miss, reset asserted on beat 3 of the fill
        bus.inct_arvalid_i = 1'b1;
        bus.inct_araddr_i  = 32'h8000_00C0;
        cyc();
        bus.inct_arvalid_i = 1'b0;
        bus.miss_i         = 1'b1;
        cyc();
        bus.miss_i        = 1'b0;
        bus.mem_arready_i = 1'b1;
        #1;
        chk("miss2_mem_araddr", 64'(bus.mem_araddr_o), 64'h8000_00C0);
        cyc();
        bus.mem_arready_i = 1'b0;
        bus.mem_rvalid_i  = 1'b1;
        repeat (3) cyc();
        #1;
        chk("miss2_beat3_wbeat", 64'(bus.wbeat_o), 64'(3));
        chk("miss2_beat3_waddr", 64'(bus.waddr_o), 64'h03);
`ifdef CC_PERF_CNT_EN
        chk("perf_hit_cnt", 64'(hit_cnt), 64'(3));
        chk("perf_miss_cnt", 64'(miss_cnt), 64'(2));
`endif
        rst_n = 1'b0;
        #1;
        chk("abort_wren_data", 64'(bus.wren_data_o), 64'(0));
        chk("abort_rready", 64'(bus.mem_rready_o), 64'(0));
        chk("abort_wbeat", 64'(bus.wbeat_o), 64'(0));
        chk("abort_waddr", 64'(bus.waddr_o), 64'(0));
        chk("abort_wren_tag", 64'(bus.wren_tag_o), 64'(0));
        chk("abort_serve_offset", 64'(bus.serve_offset_o), 64'(0));
        chk("abort_mem_araddr", 64'(bus.mem_araddr_o), 64'(0));
`ifdef CC_PERF_CNT_EN
        chk("abort_hit_cnt", 64'(hit_cnt), 64'(0));
        chk("abort_miss_cnt", 64'(miss_cnt), 64'(0));
`endif
        bus.mem_rvalid_i = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("reinit_wren_tag", 64'(bus.wren_tag_o), 64'(1));
            chk("reinit_waddr", 64'(bus.waddr_o), 64'(i));
            chk("reinit_arready", 64'(bus.inct_arready_o), 64'(0));
            cyc();
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
